// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the instruction decode stage.
//   - RV32 major opcode constants
//   - aluop_e        : ALU operation class carried to rename
//   - decoded_lane_t : per-lane decode result (immediate and PC are kept
//                      outside the struct because their width follows XLEN)
//   - occ_state_e    : occupancy of the two-entry output skid buffer
package decode_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_MEM    = 3'b000,
        ALU_BRANCH = 3'b001,
        ALU_REG    = 3'b010,
        ALU_IMM    = 3'b011,
        ALU_LUI    = 3'b100,
        ALU_AUIPC  = 3'b101,
        ALU_JALR   = 3'b110,
        ALU_JAL    = 3'b111
    } aluop_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        aluop_e     aluop;
        logic [6:0] opcode;
        logic       fu_alu;
        logic       fu_mem;
        logic       illegal;
    } decoded_lane_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/decode_lane.sv
// decode_lane: purely combinational single-lane RV32 decoder.
// Build option: DECODE_IMM_EN adds the sign-extended immediate output imm_o;
// without it the immediate is produced downstream and the port is absent.
// Ports:
//   instr_i   : instruction word (bits [31:0] are decoded, XLEN >= 32)
//   lane_en_i : lane carries a real instruction; when low every field is zero
//   dec_o     : decoded register indices, ALUOp, opcode, FU select, illegal
//   imm_o     : sign-extended immediate (DECODE_IMM_EN only)
module decode_lane
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr_i,
    input  logic            lane_en_i,
    output decoded_lane_t   dec_o
`ifdef DECODE_IMM_EN
    ,
    output logic [XLEN-1:0] imm_o
`endif
);

    logic [6:0] opcode;
    assign opcode = instr_i[6:0];

    always_comb begin
        dec_o = '0;
        if (lane_en_i) begin
            dec_o.opcode = opcode;
            dec_o.fu_alu = 1'b1;
            case (opcode)
                OPC_OP_IMM: begin
                    dec_o.rs1   = instr_i[19:15];
                    dec_o.rd    = instr_i[11:7];
                    dec_o.aluop = ALU_IMM;
                end
                OPC_LUI: begin
                    dec_o.rd    = instr_i[11:7];
                    dec_o.aluop = ALU_LUI;
                end
                OPC_OP: begin
                    dec_o.rs1   = instr_i[19:15];
                    dec_o.rs2   = instr_i[24:20];
                    dec_o.rd    = instr_i[11:7];
                    dec_o.aluop = ALU_REG;
                end
                OPC_LOAD: begin
                    dec_o.rs1    = instr_i[19:15];
                    dec_o.rd     = instr_i[11:7];
                    dec_o.aluop  = ALU_MEM;
                    dec_o.fu_mem = 1'b1;
                end
                OPC_STORE: begin
                    dec_o.rs1    = instr_i[19:15];
                    dec_o.rs2    = instr_i[24:20];
                    dec_o.aluop  = ALU_MEM;
                    dec_o.fu_mem = 1'b1;
                end
                OPC_BRANCH: begin
                    dec_o.rs1   = instr_i[19:15];
                    dec_o.rs2   = instr_i[24:20];
                    dec_o.aluop = ALU_BRANCH;
                end
                OPC_JALR: begin
                    dec_o.rs1   = instr_i[19:15];
                    dec_o.rd    = instr_i[11:7];
                    dec_o.aluop = ALU_JALR;
                end
                OPC_AUIPC: begin
                    dec_o.rd    = instr_i[11:7];
                    dec_o.aluop = ALU_AUIPC;
                end
                OPC_JAL: begin
                    dec_o.rd    = instr_i[11:7];
                    dec_o.aluop = ALU_JAL;
                end
                default: begin
                    // Unknown opcode: keep only the opcode and flag it.
                    dec_o.fu_alu  = 1'b0;
                    dec_o.illegal = 1'b1;
                end
            endcase
        end
    end

`ifdef DECODE_IMM_EN
    // Immediate is first assembled as a 32-bit sign-extended value, then
    // widened to XLEN with a signed cast.
    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        if (lane_en_i) begin
            case (opcode)
                OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                OPC_STORE:
                    imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                OPC_BRANCH:
                    imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
                OPC_LUI, OPC_AUIPC:
                    imm32 = {instr_i[31:12], 12'b0};
                OPC_JAL:
                    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
                default:
                    imm32 = '0;
            endcase
        end
    end

    assign imm_o = XLEN'($signed(imm32));
`else
    // funct3/funct7 bits only feed the immediate, which is not built here.
    logic unused_imm_bits;
    assign unused_imm_bits = ^{instr_i[31:25], instr_i[14:12]};
`endif

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered WIDTH-lane decode stage with a two-entry skid
// buffer between fetch and rename.
// Build option: DECODE_IMM_EN enables immediate generation and its head/skid
// flops; otherwise out_imm is tied to zero (port list unchanged).
// Handshake: a beat transfers on a side when valid && ready are both high at
// a rising clk edge; valid never depends on ready of the same side, and
// in_ready depends only on registered occupancy and rst_n.
// Ports:
//   clk, rst_n (sync, active low), flush (drops everything, top priority)
//   in_valid/in_ready, in_instr, in_pc, in_lane_mask : fetch side
//   out_valid/out_ready, out_* decoded fields           : rename side
module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH*XLEN-1:0] in_instr,
    input  logic [WIDTH*XLEN-1:0] in_pc,
    input  logic [WIDTH-1:0]      in_lane_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_lane_valid,
    output logic [WIDTH*5-1:0]    out_rs1,
    output logic [WIDTH*5-1:0]    out_rs2,
    output logic [WIDTH*5-1:0]    out_rd,
    output logic [WIDTH*3-1:0]    out_aluop,
    output logic [WIDTH*7-1:0]    out_opcode,
    output logic [WIDTH-1:0]      out_fu_alu,
    output logic [WIDTH-1:0]      out_fu_mem,
    output logic [WIDTH-1:0]      out_illegal,
    output logic [WIDTH*XLEN-1:0] out_pc,
    output logic [WIDTH*XLEN-1:0] out_imm
);

    occ_state_e                 state_q, state_d;
    decoded_lane_t [WIDTH-1:0]  dec_in;
    decoded_lane_t [WIDTH-1:0]  head_q, head_d, skid_q, skid_d;
    logic [WIDTH*XLEN-1:0]      pc_in;
    logic [WIDTH*XLEN-1:0]      head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
    logic [WIDTH-1:0]           head_mask_q, head_mask_d, skid_mask_q, skid_mask_d;
    logic                       push, pop;
    logic                       load_head, load_skid, skid_to_head, clear_head;
`ifdef DECODE_IMM_EN
    logic [WIDTH*XLEN-1:0]      imm_in;
    logic [WIDTH*XLEN-1:0]      head_imm_q, head_imm_d, skid_imm_q, skid_imm_d;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        decode_lane #(.XLEN(XLEN)) u_decode_lane (
            .instr_i   (in_instr[i*XLEN +: XLEN]),
            .lane_en_i (in_lane_mask[i]),
            .dec_o     (dec_in[i])
`ifdef DECODE_IMM_EN
            ,
            .imm_o     (imm_in[i*XLEN +: XLEN])
`endif
        );
    end

    // Masked-off lanes carry no PC either.
    always_comb begin
        pc_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_lane_mask[i]) pc_in[i*XLEN +: XLEN] = in_pc[i*XLEN +: XLEN];
        end
    end

    assign in_ready  = (state_q != OCC_TWO) && rst_n;
    assign out_valid = (state_q != OCC_EMPTY);
    // An all-zero mask is still consumed (in_ready high) but never stored.
    assign push      = in_valid && in_ready && (|in_lane_mask);
    assign pop       = out_valid && out_ready;

    // Occupancy FSM: next state plus datapath load controls.
    always_comb begin
        state_d      = state_q;
        load_head    = 1'b0;
        load_skid    = 1'b0;
        skid_to_head = 1'b0;
        clear_head   = 1'b0;
        if (flush) begin
            state_d    = OCC_EMPTY;
            clear_head = 1'b1;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        state_d   = OCC_ONE;
                        load_head = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        load_head = 1'b1;
                    end else if (push) begin
                        state_d   = OCC_TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d    = OCC_EMPTY;
                        clear_head = 1'b1;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        state_d      = OCC_ONE;
                        skid_to_head = 1'b1;
                    end
                end
                default: begin
                    state_d    = OCC_EMPTY;
                    clear_head = 1'b1;
                end
            endcase
        end
    end

    // Head is zeroed whenever the buffer empties so idle outputs read zero.
    always_comb begin
        head_d      = head_q;
        head_pc_d   = head_pc_q;
        head_mask_d = head_mask_q;
        skid_d      = skid_q;
        skid_pc_d   = skid_pc_q;
        skid_mask_d = skid_mask_q;
        if (clear_head) begin
            head_d      = '0;
            head_pc_d   = '0;
            head_mask_d = '0;
        end else if (load_head) begin
            head_d      = dec_in;
            head_pc_d   = pc_in;
            head_mask_d = in_lane_mask;
        end else if (skid_to_head) begin
            head_d      = skid_q;
            head_pc_d   = skid_pc_q;
            head_mask_d = skid_mask_q;
        end
        if (load_skid) begin
            skid_d      = dec_in;
            skid_pc_d   = pc_in;
            skid_mask_d = in_lane_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            head_q      <= '0;
            head_pc_q   <= '0;
            head_mask_q <= '0;
            skid_q      <= '0;
            skid_pc_q   <= '0;
            skid_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            head_pc_q   <= head_pc_d;
            head_mask_q <= head_mask_d;
            skid_q      <= skid_d;
            skid_pc_q   <= skid_pc_d;
            skid_mask_q <= skid_mask_d;
        end
    end

`ifdef DECODE_IMM_EN
    always_comb begin
        head_imm_d = head_imm_q;
        skid_imm_d = skid_imm_q;
        if (clear_head)        head_imm_d = '0;
        else if (load_head)    head_imm_d = imm_in;
        else if (skid_to_head) head_imm_d = skid_imm_q;
        if (load_skid)         skid_imm_d = imm_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_imm_q <= '0;
            skid_imm_q <= '0;
        end else begin
            head_imm_q <= head_imm_d;
            skid_imm_q <= skid_imm_d;
        end
    end

    assign out_imm = head_imm_q;
`else
    assign out_imm = '0;
`endif

    always_comb begin
        out_rs1     = '0;
        out_rs2     = '0;
        out_rd      = '0;
        out_aluop   = '0;
        out_opcode  = '0;
        out_fu_alu  = '0;
        out_fu_mem  = '0;
        out_illegal = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_rs1[i*5 +: 5]    = head_q[i].rs1;
            out_rs2[i*5 +: 5]    = head_q[i].rs2;
            out_rd[i*5 +: 5]     = head_q[i].rd;
            out_aluop[i*3 +: 3]  = head_q[i].aluop;
            out_opcode[i*7 +: 7] = head_q[i].opcode;
            out_fu_alu[i]        = head_q[i].fu_alu;
            out_fu_mem[i]        = head_q[i].fu_mem;
            out_illegal[i]       = head_q[i].illegal;
        end
    end

    assign out_lane_valid = head_mask_q;
    assign out_pc         = head_pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage (WIDTH=2, XLEN=32).
// Works with or without DECODE_IMM_EN defined.
module tb_decode_stage;

    localparam int W  = 2;
    localparam int XL = 32;
    localparam int BW = 93 * W;
`ifdef DECODE_IMM_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            flush, in_valid, in_ready, out_valid, out_ready;
    logic [W*XL-1:0] in_instr, in_pc, out_pc, out_imm;
    logic [W-1:0]    in_lane_mask, out_lane_valid, out_fu_alu, out_fu_mem, out_illegal;
    logic [W*5-1:0]  out_rs1, out_rs2, out_rd;
    logic [W*3-1:0]  out_aluop;
    logic [W*7-1:0]  out_opcode;

    decode_stage #(.WIDTH(W), .XLEN(XL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_lane_mask(in_lane_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_aluop(out_aluop), .out_opcode(out_opcode),
        .out_fu_alu(out_fu_alu), .out_fu_mem(out_fu_mem), .out_illegal(out_illegal),
        .out_pc(out_pc), .out_imm(out_imm)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int occ      = 0;            // bench model of buffer occupancy
    logic [BW-1:0] exp_q[$];

    logic [6:0] opc_tbl [10] = '{7'b0010011, 7'b0110111, 7'b0110011, 7'b0000011,
                                 7'b0100011, 7'b1100011, 7'b1100111, 7'b0010111,
                                 7'b1101111, 7'b0001011};

    // ---------------- reference model ----------------
    function automatic logic [BW-1:0] model(input logic [W*XL-1:0] instr,
                                            input logic [W*XL-1:0] pc,
                                            input logic [W-1:0] mask);
        logic [W-1:0]    lv, fa, fm, il;
        logic [W*5-1:0]  r1, r2, rd;
        logic [W*3-1:0]  al;
        logic [W*7-1:0]  op;
        logic [W*XL-1:0] pcs, im;
        logic [31:0]     x, imm;
        logic [4:0]      s1, s2, d;
        logic [2:0]      a;
        logic            alu, mem, ill;
        lv = '0; fa = '0; fm = '0; il = '0; r1 = '0; r2 = '0; rd = '0;
        al = '0; op = '0; pcs = '0; im = '0;
        for (int i = 0; i < W; i++) begin
            x = instr[i*XL +: XL];
            s1 = 5'd0; s2 = 5'd0; d = 5'd0; a = 3'd0; imm = 32'd0;
            alu = 1'b1; mem = 1'b0; ill = 1'b0;
            case (x[6:0])
                7'b0010011: begin s1 = x[19:15]; d = x[11:7]; a = 3'b011;
                                  imm = 32'($signed(x[31:20])); end
                7'b0110111: begin d = x[11:7]; a = 3'b100; imm = x & 32'hFFFFF000; end
                7'b0110011: begin s1 = x[19:15]; s2 = x[24:20]; d = x[11:7]; a = 3'b010; end
                7'b0000011: begin s1 = x[19:15]; d = x[11:7]; a = 3'b000; mem = 1'b1;
                                  imm = 32'($signed(x[31:20])); end
                7'b0100011: begin s1 = x[19:15]; s2 = x[24:20]; a = 3'b000; mem = 1'b1;
                                  imm = 32'($signed({x[31:25], x[11:7]})); end
                7'b1100011: begin s1 = x[19:15]; s2 = x[24:20]; a = 3'b001;
                                  imm = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0})); end
                7'b1100111: begin s1 = x[19:15]; d = x[11:7]; a = 3'b110;
                                  imm = 32'($signed(x[31:20])); end
                7'b0010111: begin d = x[11:7]; a = 3'b101; imm = x & 32'hFFFFF000; end
                7'b1101111: begin d = x[11:7]; a = 3'b111;
                                  imm = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0})); end
                default:    begin alu = 1'b0; ill = 1'b1; end
            endcase
            if (mask[i]) begin
                lv[i] = 1'b1;
                fa[i] = alu; fm[i] = mem; il[i] = ill;
                r1[i*5 +: 5] = s1; r2[i*5 +: 5] = s2; rd[i*5 +: 5] = d;
                al[i*3 +: 3] = a;
                op[i*7 +: 7] = x[6:0];
                pcs[i*XL +: XL] = pc[i*XL +: XL];
                im[i*XL +: XL] = IMM_EN ? imm : 32'd0;
            end
        end
        return {lv, r1, r2, rd, al, op, fa, fm, il, pcs, im};
    endfunction

    function automatic logic [BW-1:0] obs_now();
        return {out_lane_valid, out_rs1, out_rs2, out_rd, out_aluop, out_opcode,
                out_fu_alu, out_fu_mem, out_illegal, out_pc, out_imm};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [W*XL-1:0] instr,
                         input logic [W*XL-1:0] pc, input logic [W-1:0] mask);
        in_valid = v; in_instr = instr; in_pc = pc; in_lane_mask = mask;
    endtask

    // One clock: at negedge check handshake and scoreboard against the model,
    // then advance the model to what the coming posedge does.
    task automatic cycle();
        logic          exp_ready, do_push, do_pop;
        logic [BW-1:0] obs;
        @(negedge clk);
        exp_ready = rst_n && (occ < 2);
        n_checks++;
        if (in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, exp_ready);
        end
        if (rst_n) begin
            n_checks++;
            if (out_valid !== (occ != 0)) begin
                n_fail++;
                $display("FAIL out_valid t=%0t got %b exp %b", $time, out_valid, occ != 0);
            end
        end
        do_push = in_valid && exp_ready && (in_lane_mask != '0);
        do_pop  = rst_n && !flush && (occ != 0) && out_ready;
        if (do_pop) begin
            obs = obs_now();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow t=%0t got %h exp none", $time, obs);
            end else if (obs !== exp_q[0]) begin
                n_fail++;
                $display("FAIL sb_beat t=%0t got %h exp %h", $time, obs, exp_q[0]);
            end
        end
        if (!rst_n || flush) begin
            exp_q.delete();
            occ = 0;
        end else begin
            if (do_pop && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                occ--;
            end
            if (do_push) begin
                exp_q.push_back(model(in_instr, in_pc, in_lane_mask));
                occ++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        repeat (3) cycle();
        n_checks++;
        if (out_valid !== 1'b0 || obs_now() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b %h exp 0", out_valid, obs_now());
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got %b exp 1", in_ready);
        end
        cycle();
    endtask

    task automatic test_addi_sw();
        out_ready = 1'b1;
        drive(1'b1, {32'h00512423, 32'h00510093}, {32'h1004, 32'h1000}, 2'b11);
        cycle();
        drive(1'b0, '0, '0, '0);
        n_checks++;
        if ({out_rd[4:0], out_rs1[4:0], out_rs2[4:0], out_aluop[2:0], out_fu_alu[0], out_fu_mem[0]}
            !== {5'd1, 5'd2, 5'd0, 3'b011, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL addi_fields got rd=%0d rs1=%0d rs2=%0d alu=%b fa=%b fm=%b exp 1 2 0 011 1 0",
                     out_rd[4:0], out_rs1[4:0], out_rs2[4:0], out_aluop[2:0], out_fu_alu[0], out_fu_mem[0]);
        end
        n_checks++;
        if (out_imm[31:0] !== (IMM_EN ? 32'd5 : 32'd0)) begin
            n_fail++;
            $display("FAIL addi_imm got %h exp %h", out_imm[31:0], IMM_EN ? 32'd5 : 32'd0);
        end
        n_checks++;
        if ({out_rs1[9:5], out_rs2[9:5], out_rd[9:5], out_aluop[5:3], out_fu_alu[1], out_fu_mem[1]}
            !== {5'd2, 5'd5, 5'd0, 3'b000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sw_fields got rs1=%0d rs2=%0d rd=%0d alu=%b fa=%b fm=%b exp 2 5 0 000 1 1",
                     out_rs1[9:5], out_rs2[9:5], out_rd[9:5], out_aluop[5:3], out_fu_alu[1], out_fu_mem[1]);
        end
        n_checks++;
        if (out_imm[63:32] !== (IMM_EN ? 32'd8 : 32'd0)) begin
            n_fail++;
            $display("FAIL sw_imm got %h exp %h", out_imm[63:32], IMM_EN ? 32'd8 : 32'd0);
        end
        cycle();
    endtask

    task automatic test_lui_mask();
        out_ready = 1'b1;
        drive(1'b1, {32'h00512423, 32'h123451B7}, {32'h2004, 32'h2000}, 2'b01);
        cycle();
        drive(1'b0, '0, '0, '0);
        n_checks++;
        if ({out_rd[4:0], out_aluop[2:0], out_lane_valid} !== {5'd3, 3'b100, 2'b01}) begin
            n_fail++;
            $display("FAIL lui_fields got rd=%0d alu=%b lv=%b exp 3 100 01",
                     out_rd[4:0], out_aluop[2:0], out_lane_valid);
        end
        n_checks++;
        if (out_imm[31:0] !== (IMM_EN ? 32'h12345000 : 32'd0)) begin
            n_fail++;
            $display("FAIL lui_imm got %h exp %h", out_imm[31:0], IMM_EN ? 32'h12345000 : 32'd0);
        end
        n_checks++;
        if ({out_rs1[9:5], out_rs2[9:5], out_rd[9:5], out_aluop[5:3], out_opcode[13:7],
             out_fu_alu[1], out_fu_mem[1], out_illegal[1], out_pc[63:32], out_imm[63:32]} !== '0) begin
            n_fail++;
            $display("FAIL lane1_masked got nonzero fields exp 0");
        end
        cycle();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(1'b1, {32'h0, 32'hFFFFFFFF}, {32'h0, 32'h3000}, 2'b01);
        cycle();
        drive(1'b0, '0, '0, '0);
        n_checks++;
        if ({out_illegal[0], out_opcode[6:0], out_fu_alu[0], out_fu_mem[0],
             out_rs1[4:0], out_rs2[4:0], out_rd[4:0], out_aluop[2:0]}
            !== {1'b1, 7'h7F, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL illegal_lane got il=%b op=%h fa=%b regs=%0d/%0d/%0d exp 1 7f 0 0/0/0",
                     out_illegal[0], out_opcode[6:0], out_fu_alu[0],
                     out_rs1[4:0], out_rs2[4:0], out_rd[4:0]);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, {32'h00A00193, 32'h00100113}, {32'h4004, 32'h4000}, 2'b11);
        cycle();
        drive(1'b1, {32'h002081B3, 32'h00412083}, {32'h4104, 32'h4100}, 2'b11);
        cycle();
        drive(1'b1, {32'hFE208EE3, 32'h0000006F}, {32'h4204, 32'h4200}, 2'b11);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_drop got %b exp 0", in_ready);
        end
        repeat (2) cycle();
        n_checks++;
        if (out_pc[31:0] !== 32'h4000) begin
            n_fail++;
            $display("FAIL bp_hold got %h exp 00004000", out_pc[31:0]);
        end
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (out_pc[31:0] !== 32'h4100) begin
            n_fail++;
            $display("FAIL bp_second got %h exp 00004100", out_pc[31:0]);
        end
        cycle();
        n_checks++;
        if (out_pc[31:0] !== 32'h4200) begin
            n_fail++;
            $display("FAIL bp_third got %h exp 00004200", out_pc[31:0]);
        end
        drive(1'b0, '0, '0, '0);
        cycle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, {$urandom() & 32'hFFFFFF80 | 32'(opc_tbl[(i + 3) % 9]),
                         $urandom() & 32'hFFFFFF80 | 32'(opc_tbl[i % 9])},
                  {32'(32'h5000 + i * 8 + 4), 32'(32'h5000 + i * 8)}, 2'b11);
            cycle();
        end
        drive(1'b0, '0, '0, '0);
        cycle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, {32'h00100093, 32'h00200113}, {32'h6004, 32'h6000}, 2'b11);
        cycle();
        drive(1'b1, {32'h00300193, 32'h00400213}, {32'h6104, 32'h6100}, 2'b11);
        cycle();
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, {32'h00500293, 32'h00600313}, {32'h6204, 32'h6200}, 2'b11);
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs_now() !== '0) begin
            n_fail++;
            $display("FAIL flush_state got v=%b rdy=%b %h exp v=0 rdy=1 zero",
                     out_valid, in_ready, obs_now());
        end
        repeat (3) cycle();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b1, {32'h0, 32'h00A00513}, {32'h0, 32'h7000}, 2'b01);
        cycle();
        drive(1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready_low got %b exp 0", in_ready);
        end
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || obs_now() !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got v=%b %h exp 0", out_valid, obs_now());
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready got %b exp 1", in_ready);
        end
        out_ready = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_random();
        logic [31:0] i0, i1;
        for (int n = 0; n < 80; n++) begin
            i0 = ($urandom() & 32'hFFFFFF80) | 32'(opc_tbl[$urandom_range(0, 9)]);
            i1 = ($urandom() & 32'hFFFFFF80) | 32'(opc_tbl[$urandom_range(0, 9)]);
            drive($urandom_range(0, 3) != 0, {i1, i0}, {$urandom(), $urandom()},
                  2'($urandom_range(0, 3)));
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        repeat (3) cycle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain got %0d left exp 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi_sw();
        test_lui_mask();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction-decode stage between fetch and rename. It decodes `WIDTH` instruction lanes per cycle into register indices, ALUOp, opcode, functional-unit select, immediate and an illegal-instruction flag. Results are held in a two-entry skid buffer with a valid/ready handshake on both sides, so backpressure from rename never produces a combinational path back to fetch. A synchronous flush discards everything buffered.

## Interface
- `WIDTH`, default 2: decode lanes per beat, 1..4.
- `XLEN`, default 32: instruction, PC and immediate width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `flush` in 1: discard all buffered beats; has priority over every other event.
- `in_valid` in 1: fetch beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_instr` in WIDTH*XLEN: instruction per lane; lane i is bits [i*XLEN +: XLEN].
- `in_pc` in WIDTH*XLEN: PC per lane.
- `in_lane_mask` in WIDTH: lane i carries a real instruction.
- `out_valid` out 1: decoded beat valid.
- `out_ready` in 1: rename accepts the beat.
- `out_lane_valid` out WIDTH: registered copy of the lane mask.
- `out_rs1`, `out_rs2`, `out_rd` out WIDTH*5: register indices.
- `out_aluop` out WIDTH*3: ALU operation class.
- `out_opcode` out WIDTH*7: instr[6:0].
- `out_fu_alu`, `out_fu_mem` out WIDTH: functional-unit select.
- `out_illegal` out WIDTH: unknown opcode.
- `out_pc` out WIDTH*XLEN: passthrough PC.
- `out_imm` out WIDTH*XLEN: sign-extended immediate.

## Operation
- Per-lane decode, all other fields zero unless stated:
  - OP-IMM 0010011: rs1, rd; aluop 011; alu.
  - LUI 0110111: rd; aluop 100; alu.
  - OP 0110011: rs1, rs2, rd; aluop 010; alu.
  - LOAD 0000011: rs1, rd; aluop 000; alu and mem.
  - STORE 0100011: rs1, rs2; aluop 000; alu and mem.
  - BRANCH 1100011: rs1, rs2; aluop 001; alu.
  - JALR 1100111: rs1, rd; aluop 110; alu.
  - AUIPC 0010111: rd; aluop 101; alu.
  - JAL 1101111: rd; aluop 111; alu.
- Any other opcode: all fields zero, illegal=1. Opcode is still reported.
- Lanes with mask=0: every field zero, illegal=0, lane_valid=0.
- Occupancy FSM with states EMPTY, ONE and TWO.
  - Push: `in_valid && in_ready` with a nonzero mask.
  - Pop: `out_valid && out_ready`.
  - EMPTY: push goes to ONE.
  - ONE: push with pop stays ONE and the head is replaced. Push alone goes to TWO. Pop alone goes to EMPTY.
  - TWO: pop goes to ONE and the skid entry moves to head. No push is possible in TWO.
- A beat with `in_valid && in_ready` and an all-zero mask is consumed and dropped. No state change.
- `flush`: next state EMPTY, regardless of in_valid/out_ready that cycle. The incoming beat is dropped.
- Order is strictly FIFO. Beats are never reordered or split.

## Timing
- Latency is 1 cycle: a beat pushed at edge N is visible on out_* after edge N.
- Throughput is one beat per cycle while out_ready=1.
- `in_ready` = (state != TWO) && rst_n. It depends only on registered state and rst_n, with no path from out_ready.
- out_* are driven directly from the head register. Fields are held stable while out_valid=1 and out_ready=0.
- Reset, and the cycle after flush: state EMPTY, out_valid=0, all out_* fields zero.
- in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Reset asserted mid-operation discards buffered beats exactly like flush.

## Configuration
- `DECODE_IMM_EN` defined: out_imm is computed per format and sign-extended to XLEN.
  - I-type: OP-IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - OP and illegal lanes give 0.
- `DECODE_IMM_EN` undefined: out_imm is tied to zero, the immediate is generated downstream, and no immediate flops are instantiated. The port list is unchanged.

## Structure
- `decode_pkg` holds:
  - opcode localparams;
  - ALUOp enum (000 mem, 001 branch, 010 reg, 011 imm, 100 lui, 101 auipc, 110 jalr, 111 jal);
  - the `decoded_lane_t` struct;
  - the occupancy state enum.
- Sub-module `decode_lane`: purely combinational single-lane decoder plus immediate generator. It is generated `WIDTH` times.
- Top level: the FSM, head/skid registers of `WIDTH` × `decoded_lane_t` plus pc and lane_valid, and the handshake logic.

## Test plan
- WIDTH=2. Lane0 0x00510093 (addi x1,x2,5), lane1 0x00512423 (sw x5,8(x2)), mask 11, out_ready=1.
  - Next cycle, lane0: rd=1, rs1=2, rs2=0, aluop=011, fu_alu=1, fu_mem=0, imm=5.
  - Lane1: rs1=2, rs2=5, rd=0, aluop=000, fu_mem=1, imm=8.
- Lane0 0x123451B7 (lui x3) with mask 01.
  - Lane0: rd=3, aluop=100, imm=0x12345000.
  - Lane1: all zero, lane_valid=0.
  - Without `DECODE_IMM_EN`, imm=0.
- Lane0 0xFFFFFFFF: illegal=1, opcode=7'h7F, fu_alu=0, all register fields 0.
- Backpressure: hold out_ready=0 and push three consecutive beats.
  - The first two are accepted; in_ready drops after the second.
  - out fields hold beat 1.
  - Release out_ready: beats 1 and 2 emerge in order on consecutive cycles; beat 3 is accepted the cycle after the first pop.
- State TWO, assert flush together with in_valid and out_ready.
  - Next cycle: out_valid=0, in_ready=1.
  - No flushed beat ever appears on the output.
- Reset mid-stream: rst_n=0 for one cycle while in state ONE. Then out_valid=0, outputs zero, in_ready=0 during reset and 1 after.
